// File: rtl/mod_updown_counter_pkg.sv
// ----------------------------------------------------------------------------
// mod_updown_counter_pkg
// Shared definitions for the modulo up/down counter and its prescaler:
//   MODE_WRAP / MODE_SAT : values for the SAT parameter of the counter
//   clog2()              : ceiling log2, used to size the prescaler register
// ----------------------------------------------------------------------------
package mod_updown_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // clog2(1) = 0, clog2(3) = 2, clog2(256) = 8
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// ----------------------------------------------------------------------------
// mod_updown_counter_if
// Control and status bundle of the modulo up/down counter.
//   master : drives syn_clr, load, en, up, d; observes q and the tick flags
//   slave  : the counter side (mod_updown_counter)
//   syn_clr  synchronous clear          load     synchronous load of d
//   en       count enable (prescaled)   up       1 = count up, 0 = count down
//   d        load data (N bits)         q        registered count (N bits)
//   max_tick q == M-1                   min_tick q == 0
//   ovf_tick one-cycle pulse after a boundary step
// ----------------------------------------------------------------------------
interface mod_updown_counter_if #(
    parameter int N = 8
);
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         max_tick;
    logic         min_tick;
    logic         ovf_tick;

    modport master (
        output syn_clr, load, en, up, d,
        input  q, max_tick, min_tick, ovf_tick
    );

    modport slave (
        input  syn_clr, load, en, up, d,
        output q, max_tick, min_tick, ovf_tick
    );
endinterface

// File: rtl/mod_updown_counter_tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Divides the enable stream by PRE: step is high on every PRE-th enabled cycle.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (partial count discarded)
//   clr      synchronous restart of the prescale count; also blocks step
//   en       enable, counts one prescale cycle
//   step     combinational, high in the cycle the count reaches PRE-1
// ----------------------------------------------------------------------------
module tick_prescaler
    import mod_updown_counter_pkg::*;
#(
    parameter int PRE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam int W = (clog2(PRE) < 1) ? 1 : clog2(PRE);

    generate
        if (PRE == 1) begin : g_bypass
            // No state needed: every enabled cycle is a step.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset_n;
            assign step = en & ~clr;
        end else begin : g_count
            localparam logic [W-1:0] TERM = W'(PRE - 1);

            logic [W-1:0] cnt;
            logic         at_term;

            assign at_term = (cnt == TERM);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= at_term ? '0 : cnt + W'(1);
                end
            end

            assign step = en & ~clr & at_term;
        end
    endgenerate

endmodule

// File: rtl/mod_updown_counter.sv
// ----------------------------------------------------------------------------
// mod_updown_counter
// Modulo-M up/down counter with synchronous clear/load, prescaled enable and
// selectable wrap or saturate behaviour at the 0 / M-1 boundaries.
//   Parameters: N (width), M (modulus, q in 0..M-1), PRE (prescale ratio),
//               SAT (MODE_WRAP or MODE_SAT)
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mod_updown_counter_if.slave: syn_clr, load, en, up, d in;
//            q, max_tick, min_tick, ovf_tick out
// Priority per cycle: syn_clr > load > step > hold.
// ----------------------------------------------------------------------------
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int N   = 8,
    parameter int M   = 2 ** N,
    parameter int PRE = 1,
    parameter int SAT = MODE_WRAP
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mod_updown_counter_if.slave  bus
);

    // M itself needs N+1 bits when M = 2**N.
    localparam logic [N:0]   M_EXT = (N + 1)'(M);
    localparam logic [N-1:0] Q_MAX = N'(M - 1);

    logic [N-1:0] q_r;
    logic [N-1:0] q_next;
    logic [N-1:0] d_clamped;
    logic [N:0]   q_inc;
    logic [N:0]   q_dec;
    logic         wrap_up;
    logic         wrap_dn;
    logic         ovf_r;
    logic         ovf_next;
    logic         clr_pre;
    logic         step;

    // Clear and load both restart the prescale and swallow a coincident step.
    assign clr_pre = bus.syn_clr | bus.load;

    tick_prescaler #(
        .PRE (PRE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_pre),
        .en      (bus.en),
        .step    (step)
    );

    always_comb begin
        q_inc     = {1'b0, q_r} + (N + 1)'(1);
        q_dec     = {1'b0, q_r} - (N + 1)'(1);
        // q never exceeds M-1, so q+1 == M marks the top boundary and a borrow
        // out of the extended subtractor marks the bottom one.
        wrap_up   = (q_inc == M_EXT);
        wrap_dn   = q_dec[N];
        d_clamped = ({1'b0, bus.d} >= M_EXT) ? Q_MAX : bus.d;

        q_next    = q_r;
        ovf_next  = 1'b0;

        if (bus.syn_clr) begin
            q_next = '0;
        end else if (bus.load) begin
            q_next = d_clamped;
        end else if (step) begin
            if (bus.up) begin
                if (wrap_up) begin
                    ovf_next = 1'b1;
                    q_next   = (SAT == MODE_SAT) ? Q_MAX : '0;
                end else begin
                    q_next   = q_inc[N-1:0];
                end
            end else begin
                if (wrap_dn) begin
                    ovf_next = 1'b1;
                    q_next   = (SAT == MODE_SAT) ? '0 : Q_MAX;
                end else begin
                    q_next   = q_dec[N-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r   <= '0;
            ovf_r <= 1'b0;
        end else begin
            q_r   <= q_next;
            ovf_r <= ovf_next;
        end
    end

    assign bus.q        = q_r;
    assign bus.ovf_tick = ovf_r;
    assign bus.max_tick = (q_r == Q_MAX);
    assign bus.min_tick = (q_r == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_mod_updown_counter
// Three counters driven with identical stimulus:
//   A: N=4 M=10 PRE=1 wrap     B: N=4 M=10 PRE=3 saturate
//   C: N=3 M=2**N (default) PRE=1 wrap
// A reference model computes the expected state per cycle and pushes it into
// a scoreboard queue; a monitor pops one entry after every clock edge.
// ----------------------------------------------------------------------------
module tb_mod_updown_counter;
    import mod_updown_counter_pkg::*;

    localparam int NA = 4, MA = 10, PA = 1, SA = MODE_WRAP;
    localparam int NB = 4, MB = 10, PB = 3, SB = MODE_SAT;
    localparam int NC = 3, MC = 8,  PC = 1, SC = MODE_WRAP;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    mod_updown_counter_if #(.N(NA)) ifa ();
    mod_updown_counter_if #(.N(NB)) ifb ();
    mod_updown_counter_if #(.N(NC)) ifc ();

    mod_updown_counter #(.N(NA), .M(MA), .PRE(PA), .SAT(SA)) dut_a (
        .clk (clk), .reset_n (reset_n), .bus (ifa)
    );
    mod_updown_counter #(.N(NB), .M(MB), .PRE(PB), .SAT(SB)) dut_b (
        .clk (clk), .reset_n (reset_n), .bus (ifb)
    );
    mod_updown_counter #(.N(NC), .PRE(PC), .SAT(SC)) dut_c (
        .clk (clk), .reset_n (reset_n), .bus (ifc)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    int cfg_m   [3] = '{MA, MB, MC};
    int cfg_pre [3] = '{PA, PB, PC};
    int cfg_sat [3] = '{SA, SB, SC};
    int mq      [3];
    int mpre    [3];   // enabled cycles seen since the last step
    bit movf    [3];

    typedef struct packed {
        logic [3:0] qa;
        logic [3:0] qb;
        logic [2:0] qc;
        logic [2:0] ovf;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i]   = 0;
            mpre[i] = 0;
            movf[i] = 1'b0;
        end
    endfunction

    function automatic void model_apply(bit clr, bit ld, bit e, bit u, int dv);
        for (int i = 0; i < 3; i++) begin
            int dd;
            dd = (i == 2) ? (dv % 8) : dv;
            movf[i] = 1'b0;
            if (clr) begin
                mq[i] = 0; mpre[i] = 0;
            end else if (ld) begin
                mq[i] = (dd >= cfg_m[i]) ? cfg_m[i] - 1 : dd;
                mpre[i] = 0;
            end else if (e) begin
                mpre[i] = mpre[i] + 1;
                if (mpre[i] == cfg_pre[i]) begin
                    mpre[i] = 0;
                    if (u) begin
                        if (mq[i] == cfg_m[i] - 1) begin
                            movf[i] = 1'b1;
                            mq[i] = (cfg_sat[i] == 1) ? mq[i] : 0;
                        end else begin
                            mq[i] = mq[i] + 1;
                        end
                    end else begin
                        if (mq[i] == 0) begin
                            movf[i] = 1'b1;
                            mq[i] = (cfg_sat[i] == 1) ? 0 : cfg_m[i] - 1;
                        end else begin
                            mq[i] = mq[i] - 1;
                        end
                    end
                end
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic put_inputs(input bit clr, input bit ld, input bit e, input bit u, input int dv);
        ifa.syn_clr = clr; ifa.load = ld; ifa.en = e; ifa.up = u; ifa.d = 4'(dv);
        ifb.syn_clr = clr; ifb.load = ld; ifb.en = e; ifb.up = u; ifb.d = 4'(dv);
        ifc.syn_clr = clr; ifc.load = ld; ifc.en = e; ifc.up = u; ifc.d = 3'(dv);
    endtask

    task automatic drive(input bit clr, input bit ld, input bit e, input bit u, input int dv);
        exp_t ex;
        @(negedge clk);
        put_inputs(clr, ld, e, u, dv);
        model_apply(clr, ld, e, u, dv);
        ex.qa  = 4'(mq[0]);
        ex.qb  = 4'(mq[1]);
        ex.qc  = 3'(mq[2]);
        ex.ovf = {movf[2], movf[1], movf[0]};
        sbq.push_back(ex);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Reset asserted between edges; outputs must clear at once.
    task automatic async_reset(input string tag);
        drive(0, 0, 0, 1, 0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk({tag, "_a_q"},   ifa.q, 0);
        chk({tag, "_b_q"},   ifb.q, 0);
        chk({tag, "_c_q"},   ifc.q, 0);
        chk({tag, "_a_min"}, ifa.min_tick, 1);
        chk({tag, "_b_min"}, ifb.min_tick, 1);
        chk({tag, "_a_max"}, ifa.max_tick, 0);
        chk({tag, "_a_ovf"}, ifa.ovf_tick, 0);
        chk({tag, "_b_ovf"}, ifb.ovf_tick, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("a_q",   ifa.q,        mon_e.qa);
                chk("a_ovf", ifa.ovf_tick, mon_e.ovf[0]);
                chk("a_max", ifa.max_tick, (mon_e.qa == 4'(MA - 1)) ? 1 : 0);
                chk("a_min", ifa.min_tick, (mon_e.qa == 4'd0) ? 1 : 0);
                chk("b_q",   ifb.q,        mon_e.qb);
                chk("b_ovf", ifb.ovf_tick, mon_e.ovf[1]);
                chk("b_max", ifb.max_tick, (mon_e.qb == 4'(MB - 1)) ? 1 : 0);
                chk("b_min", ifb.min_tick, (mon_e.qb == 4'd0) ? 1 : 0);
                chk("c_q",   ifc.q,        mon_e.qc);
                chk("c_ovf", ifc.ovf_tick, mon_e.ovf[2]);
                chk("c_max", ifc.max_tick, (mon_e.qc == 3'(MC - 1)) ? 1 : 0);
                chk("c_min", ifc.min_tick, (mon_e.qc == 3'd0) ? 1 : 0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int rnd;
    bit r_clr, r_ld, r_en;
    bit r_up = 1'b1;

    initial begin
        model_reset();
        put_inputs(0, 0, 0, 1, 0);
        #1 reset_n = 1'b0;
        #2;
        chk("rst_a_q",   ifa.q, 0);
        chk("rst_a_min", ifa.min_tick, 1);
        chk("rst_a_max", ifa.max_tick, 0);
        chk("rst_a_ovf", ifa.ovf_tick, 0);
        chk("rst_b_q",   ifb.q, 0);
        chk("rst_c_min", ifc.min_tick, 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // 12 up counts from reset: A runs 1..9, 0, 1, 2
        for (int i = 0; i < 12; i++) drive(0, 0, 1, 1, 0);
        after_edge();
        chk("up12_a_q", ifa.q, 2);
        chk("up12_b_q", ifb.q, 4);
        chk("up12_c_q", ifc.q, 4);

        // load clamp, then saturation at the top for B
        drive(0, 1, 0, 1, 15);
        after_edge();
        chk("clamp_a_q", ifa.q, 9);
        chk("clamp_b_q", ifb.q, 9);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 1, 0);
        after_edge();
        chk("sat_b_q",   ifb.q, 9);
        chk("sat_b_ovf", ifb.ovf_tick, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
        after_edge();
        chk("satdn_b_q", ifb.q, 8);

        // clear after two enabled cycles restarts the 3-cycle prescale
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 0);
        after_edge();
        chk("pre_b_q_2", ifb.q, 0);
        drive(0, 0, 1, 1, 0);
        after_edge();
        chk("pre_b_q_3", ifb.q, 1);

        // down step from 0 wraps to M-1
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        after_edge();
        chk("dnwrap_a_q",   ifa.q, 9);
        chk("dnwrap_a_ovf", ifa.ovf_tick, 1);
        chk("dnwrap_a_max", ifa.max_tick, 1);
        chk("dnwrap_c_q",   ifc.q, 7);

        // clear beats load and step
        drive(0, 1, 0, 1, 7);
        drive(1, 1, 1, 1, 5);
        after_edge();
        chk("clrld_a_q",   ifa.q, 0);
        chk("clrld_a_ovf", ifa.ovf_tick, 0);
        chk("clrld_b_q",   ifb.q, 0);

        // load on a prescaler terminal cycle suppresses the step
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 1, 1, 1, 9);
        after_edge();
        chk("ldterm_b_q",   ifb.q, 9);
        chk("ldterm_b_ovf", ifb.ovf_tick, 0);

        // async reset mid-prescale at q = 7
        drive(0, 1, 0, 1, 7);
        drive(0, 0, 1, 1, 0);
        async_reset("arst");
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 0);
        after_edge();
        chk("arst_b_q_2", ifb.q, 0);
        drive(0, 0, 1, 1, 0);
        after_edge();
        chk("arst_b_q_3", ifb.q, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset("rrst");
            rnd   = $urandom_range(0, 99);
            r_clr = (rnd < 3);
            r_ld  = (rnd >= 3) && (rnd < 8);
            r_en  = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 15) == 0) r_up = ~r_up;
            drive(r_clr, r_ld, r_en, r_up, int'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
